osc_freq_lock: RTL and testbench

//  Frequency-lock controller that closes the loop around the ring oscillator.
//  - Counts edges of a divided oscillator phase over a fixed ref_clk window.
//  - Binary-searches (SAR) the 13-bit delay code {delay_con_msb, delay_con_lsb} until the count meets target_cnt.
//  - After calibration, enables injection and can optionally keep tracking drift.

---
 rtl/osc_freq_lock.sv | 256 +++++++++++++++++++++++++
 tb/tb_osc_freq_lock.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/osc_freq_lock.sv
// -----------------------------------------------------------------------------
// osc_freq_lock
// Frequency-lock controller for the ring oscillator. A divided oscillator
// phase is synchronised into the ref_clk domain and its rising edges are
// counted over a fixed window. A 13-bit successive-approximation search over
// the delay code then finds the slowest code whose count still meets
// i_target_cnt. After that the oscillator injection is enabled.
//
// Optional feature (compile-time macro FLL_TRACK_EN):
//   When defined, calibration does not stop in a DONE state. The controller
//   keeps measuring and nudges the code by +/-1 per window whenever the count
//   leaves a +/-LOCK_TOL dead-band around the target.
//   When undefined, the code is frozen once the search completes.
// -----------------------------------------------------------------------------
module osc_freq_lock #(
    parameter int WIN_LOG2   = 8,   // window = 2**WIN_LOG2 ref_clk cycles
    parameter int CNT_W      = 12,  // edge-counter / target width
    parameter int SETTLE_CYC = 16,  // wait after each code change
    parameter int LOCK_TOL   = 2    // tracking dead-band (tracking build only)
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_glob_en,
    input  logic             i_start,
    input  logic             i_osc_div,
    input  logic [CNT_W-1:0] i_target_cnt,
    output logic [4:0]       o_delay_con_lsb,
    output logic [7:0]       o_delay_con_msb,
    output logic             o_inj_en,
    output logic             o_cal_done,
    output logic [CNT_W-1:0] o_meas_cnt
);

    localparam int CODE_W  = 13;
    localparam int WIN_LEN = 1 << WIN_LOG2;
    localparam int TMR_MAX = (WIN_LEN > SETTLE_CYC) ? WIN_LEN : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'(WIN_LEN - 1);
    localparam logic [CODE_W-1:0] CODE_SLOW   = 13'h1FFF;
    localparam logic [CODE_W-1:0] CODE_MID    = 13'h1000;

`ifdef FLL_TRACK_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_MEAS   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_TRACK  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_MEAS   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`endif

    // Registered state
    state_t              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [3:0]          r_bit;
    logic [TMR_W-1:0]    r_tmr;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic [CNT_W-1:0]    r_meas_cnt;
    logic                r_cal_done;
    logic                r_inj_en;
    logic [1:0]          r_sync;
    logic                r_osc_prev;

    // Next-state values
    state_t              w_state_next;
    logic [CODE_W-1:0]   w_code_next;
    logic [3:0]          w_bit_next;
    logic [TMR_W-1:0]    w_tmr_next;
    logic [CNT_W-1:0]    w_edge_cnt_next;
    logic [CNT_W-1:0]    w_meas_cnt_next;
    logic                w_cal_done_next;
    logic                w_inj_en_next;

    logic                w_osc_rise;

`ifdef FLL_TRACK_EN
    logic                r_tracking;
    logic                w_tracking_next;
    logic [CNT_W:0]      w_cnt_ext;
    logic [CNT_W:0]      w_trk_hi;
    logic [CNT_W:0]      w_trk_lo;

    // Dead-band limits are formed one bit wider so target+tol cannot wrap
    // and target-tol floors at zero.
    assign w_cnt_ext = {1'b0, r_edge_cnt};
    assign w_trk_hi  = {1'b0, i_target_cnt} + (CNT_W+1)'(LOCK_TOL);
    assign w_trk_lo  = ({1'b0, i_target_cnt} >= (CNT_W+1)'(LOCK_TOL)) ?
                       ({1'b0, i_target_cnt} - (CNT_W+1)'(LOCK_TOL)) :
                       '0;
`endif

    // Rising edge of the synchronised oscillator phase
    assign w_osc_rise = r_sync[1] & ~r_osc_prev;

    // State, datapath and synchroniser registers
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_code     <= CODE_SLOW;
            r_bit      <= 4'd0;
            r_tmr      <= '0;
            r_edge_cnt <= '0;
            r_meas_cnt <= '0;
            r_cal_done <= 1'b0;
            r_inj_en   <= 1'b0;
            r_sync     <= 2'b00;
            r_osc_prev <= 1'b0;
`ifdef FLL_TRACK_EN
            r_tracking <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_code     <= w_code_next;
            r_bit      <= w_bit_next;
            r_tmr      <= w_tmr_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_meas_cnt <= w_meas_cnt_next;
            r_cal_done <= w_cal_done_next;
            r_inj_en   <= w_inj_en_next;
            r_sync     <= {r_sync[0], i_osc_div};
            r_osc_prev <= r_sync[1];
`ifdef FLL_TRACK_EN
            r_tracking <= w_tracking_next;
`endif
        end
    end

    // Next-state logic: SAR sequencing, window timing and edge counting
    always_comb begin
        w_state_next    = r_state;
        w_code_next     = r_code;
        w_bit_next      = r_bit;
        w_tmr_next      = r_tmr;
        w_edge_cnt_next = r_edge_cnt;
        w_meas_cnt_next = r_meas_cnt;
        w_cal_done_next = r_cal_done;
        w_inj_en_next   = r_inj_en;
`ifdef FLL_TRACK_EN
        w_tracking_next = r_tracking;
`endif

        if (!i_glob_en) begin
            // Disable wins in every state; the code is deliberately kept.
            w_state_next    = ST_IDLE;
            w_cal_done_next = 1'b0;
            w_inj_en_next   = 1'b0;
`ifdef FLL_TRACK_EN
            w_tracking_next = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_code_next  = CODE_MID;
                        w_bit_next   = 4'd12;
                        w_tmr_next   = '0;
                        w_state_next = ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (r_tmr == SETTLE_LAST) begin
                        w_tmr_next      = '0;
                        w_edge_cnt_next = '0;
                        w_state_next    = ST_MEAS;
                    end else begin
                        w_tmr_next = r_tmr + TMR_W'(1);
                    end
                end

                ST_MEAS: begin
                    // Saturating count so a runaway oscillator cannot wrap
                    // into a small, misleading value.
                    if (w_osc_rise && (r_edge_cnt != '1)) begin
                        w_edge_cnt_next = r_edge_cnt + CNT_W'(1);
                    end
                    if (r_tmr == WIN_LAST) begin
                        w_tmr_next = '0;
`ifdef FLL_TRACK_EN
                        w_state_next = r_tracking ? ST_TRACK : ST_DECIDE;
`else
                        w_state_next = ST_DECIDE;
`endif
                    end else begin
                        w_tmr_next = r_tmr + TMR_W'(1);
                    end
                end

                ST_DECIDE: begin
                    w_meas_cnt_next = r_edge_cnt;
                    // Too slow: drop this bit (lower code = faster).
                    // Equal or faster: keep it, staying as slow as allowed.
                    if (r_edge_cnt < i_target_cnt) begin
                        w_code_next[r_bit] = 1'b0;
                    end
                    if (r_bit != 4'd0) begin
                        w_code_next[r_bit - 4'd1] = 1'b1;
                        w_bit_next   = r_bit - 4'd1;
                        w_state_next = ST_SETTLE;
                    end else begin
                        w_cal_done_next = 1'b1;
                        w_inj_en_next   = 1'b1;
`ifdef FLL_TRACK_EN
                        w_tracking_next = 1'b1;
                        w_state_next    = ST_SETTLE;
`else
                        w_state_next    = ST_DONE;
`endif
                    end
                end

`ifdef FLL_TRACK_EN
                ST_TRACK: begin
                    w_meas_cnt_next = r_edge_cnt;
                    if (w_cnt_ext > w_trk_hi) begin
                        if (r_code != CODE_SLOW) begin
                            w_code_next = r_code + 13'd1;
                        end
                    end else if (w_cnt_ext < w_trk_lo) begin
                        if (r_code != '0) begin
                            w_code_next = r_code - 13'd1;
                        end
                    end
                    w_state_next = ST_SETTLE;
                end
`else
                ST_DONE: begin
                    // Code frozen; only a glob_en drop leaves this state.
                    w_state_next = ST_DONE;
                end
`endif

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign o_delay_con_lsb = r_code[4:0];
    assign o_delay_con_msb = r_code[12:5];
    assign o_inj_en        = r_inj_en;
    assign o_cal_done      = r_cal_done;
    assign o_meas_cnt      = r_meas_cnt;

endmodule

// File: tb/tb_osc_freq_lock.sv
// -----------------------------------------------------------------------------
// tb_osc_freq_lock
// Closed-loop bench: a behavioural oscillator emits a code-dependent number of
// osc_div pulses inside each measurement window. Expected per-step results are
// queued when a calibration is launched and popped as each step completes.
// Oscillator model: edges per window = 63 - (code >> 7)  (monotone, slower at
// higher code), so the lock code for target T is (64-T)*128-1.
// -----------------------------------------------------------------------------
module tb_osc_freq_lock;

    localparam int STEP_CYC = 16 + 256 + 1;

    logic        clk;
    logic        rst;
    logic        glob_en;
    logic        start;
    logic        osc_div;
    logic [11:0] target;
    logic [4:0]  delay_lsb;
    logic [7:0]  delay_msb;
    logic        inj_en;
    logic        cal_done;
    logic [11:0] meas_cnt;

    typedef struct {
        int meas;
        int code;
    } step_exp_t;

    step_exp_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;

    osc_freq_lock dut (
        .i_ref_clk       (clk),
        .i_rst           (rst),
        .i_glob_en       (glob_en),
        .i_start         (start),
        .i_osc_div       (osc_div),
        .i_target_cnt    (target),
        .o_delay_con_lsb (delay_lsb),
        .o_delay_con_msb (delay_msb),
        .o_inj_en        (inj_en),
        .o_cal_done      (cal_done),
        .o_meas_cnt      (meas_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cur_code();
        return int'({delay_msb, delay_lsb});
    endfunction

    function automatic int osc_edges(input int code);
        return 63 - (code >> 7);
    endfunction

    // Expected per-step window count and resulting code for a full search.
    task automatic push_expected(input int tgt);
        int code;
        int n;
        code = 32'h1000;
        for (int b = 12; b >= 0; b--) begin
            n = osc_edges(code);
            if (n < tgt) code = code & ~(1 << b);
            if (b > 0) code = code | (1 << (b - 1));
            sb_q.push_back('{n, code});
        end
    endtask

    // mode 0: plain run; 1: stray start pulses in step 3;
    // 2: glob_en dropped in step 5; 3: async reset in step 2 (mid-MEAS).
    task automatic run_cal(input int tgt, input int mode, input int exp_final);
        int n;
        int prev_code;
        step_exp_t e;
        @(negedge clk);
        target = 12'(tgt);
        start  = 1'b1;
        push_expected(tgt);
        prev_code = 32'h1000;
        @(posedge clk);
        for (int s = 1; s <= 13; s++) begin
            n = 0;
            for (int c = 1; c <= STEP_CYC; c++) begin
                @(negedge clk);
                if (c == 1) n = osc_edges(cur_code());
                start   = (mode == 1 && s == 3 && (c == 5 || c == 100));
                osc_div = (c >= 20 && ((c - 20) % 4) < 2 && ((c - 20) / 4) < n);
                if (mode == 2 && s == 5 && c == 100) begin
                    glob_en = 1'b0;
                    @(posedge clk);
                    #1;
                    check_val("drop_cal_done", cal_done, 1'b0);
                    check_val("drop_inj_en", inj_en, 1'b0);
                    check_val("drop_code_held", cur_code(), prev_code);
                    repeat (5) @(posedge clk);
                    #1;
                    check_val("idle_code_held", cur_code(), prev_code);
                    @(negedge clk);
                    glob_en = 1'b1;
                    osc_div = 1'b0;
                    sb_q.delete();
                    $display("glob_en dropped in step 5, code=%04h", cur_code());
                    return;
                end
                if (mode == 3 && s == 2 && c == 100) begin
                    #2 rst = 1'b1;
                    #1;
                    check_val("arst_code", cur_code(), 32'h1FFF);
                    check_val("arst_cal_done", cal_done, 1'b0);
                    check_val("arst_inj_en", inj_en, 1'b0);
                    check_val("arst_meas_cnt", meas_cnt, 32'h0);
                    @(negedge clk);
                    rst     = 1'b0;
                    osc_div = 1'b0;
                    sb_q.delete();
                    $display("async reset in step 2, code=%04h", cur_code());
                    return;
                end
                @(posedge clk);
                if (s == 13 && c == STEP_CYC - 1) begin
                    #1;
                    check_val("cal_done_early", cal_done, 1'b0);
                end
            end
            #1;
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val($sformatf("step%0d_meas", s), meas_cnt, e.meas);
                check_val($sformatf("step%0d_code", s), cur_code(), e.code);
                prev_code = e.code;
                $display("step %0d target=%0d meas=%0d code=%04h", s, tgt, meas_cnt, cur_code());
            end
        end
        // 13*273+1 edges after start was raised: cal_done rises exactly here.
        check_val("cal_done_latency", cal_done, 1'b1);
        check_val("inj_en_done", inj_en, 1'b1);
        check_val("final_code", cur_code(), exp_final);
        osc_div = 1'b0;
    endtask

    // One glob_en-low cycle returns the controller to IDLE.
    task automatic go_idle();
        @(negedge clk);
        glob_en = 1'b0;
        @(negedge clk);
        glob_en = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        glob_en = 1'b1;
        start   = 1'b0;
        osc_div = 1'b0;
        target  = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_code", cur_code(), 32'h1FFF);
        check_val("rst_cal_done", cal_done, 1'b0);
        check_val("rst_inj_en", inj_en, 1'b0);
        check_val("rst_meas_cnt", meas_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Nominal lock, then start pulse in DONE must be ignored
        run_cal(40, 0, (64 - 40) * 128 - 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check_val("done_start_ignored", cal_done, 1'b1);
        check_val("done_code_frozen", cur_code(), (64 - 40) * 128 - 1);
        $display("start in DONE ignored, code=%04h", cur_code());

        // glob_en drop in DONE: flags clear next cycle, code held
        @(negedge clk); glob_en = 1'b0;
        @(posedge clk); #1;
        check_val("done_drop_cal_done", cal_done, 1'b0);
        check_val("done_drop_inj_en", inj_en, 1'b0);
        check_val("done_drop_code", cur_code(), (64 - 40) * 128 - 1);
        @(negedge clk); glob_en = 1'b1;

        // Extremes of the target range
        run_cal(0, 0, 32'h1FFF);
        go_idle();
        run_cal(4095, 0, 0);
        go_idle();

        // Disable mid-search then restart
        run_cal(40, 2, 0);
        run_cal(40, 0, (64 - 40) * 128 - 1);
        go_idle();

        // Stray start pulses during SETTLE and MEAS
        run_cal(40, 1, (64 - 40) * 128 - 1);
        go_idle();

        // Async reset mid-MEAS, then a fresh calibration
        run_cal(40, 3, 0);
        run_cal(25, 0, (64 - 25) * 128 - 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
